// File: rtl/block_match_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : block_match_scheduler
// Description : Walks the 16x16 blocks of one image third in raster order,
//               requests each from the compare engine and issues paced
//               xors_valid pulses towards the stream serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module block_match_scheduler #(
    parameter int THIRD_WIDTH     = 240,
    parameter int THIRD_HEIGHT    = 480,
    parameter int BLK_W           = 16,
    parameter int BLK_H           = 16,
    parameter int DECIMATE_FACTOR = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    output logic       blk_req,
    output logic [3:0] blk_x,
    output logic [4:0] blk_y,
    input  logic       blk_ack,
    input  logic       result_valid,
    input  logic       stream_ready,
    output logic       xors_valid,
    output logic       result_taken,
    output logic [8:0] blk_index,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       frame_overrun,
    output logic       proto_err
);

    localparam int c_blk_cols = THIRD_WIDTH / BLK_W;
    localparam int c_blk_rows = THIRD_HEIGHT / BLK_H;
    localparam int c_min_gap  = BLK_W * BLK_H / DECIMATE_FACTOR;
    localparam int c_gap_w    = $clog2(c_min_gap);

    localparam logic [c_gap_w-1:0] c_gap_reload = c_gap_w'(c_min_gap - 1);
    localparam logic [3:0]         c_last_x     = 4'(c_blk_cols - 1);
    localparam logic [4:0]         c_last_y     = 5'(c_blk_rows - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_REQ      = 2'd1;
    localparam logic [1:0] c_WAIT_RES = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_x;
    logic [3:0]         w_next_x;
    logic [4:0]         r_y;
    logic [4:0]         w_next_y;
    logic [c_gap_w-1:0] r_gap;
    logic               r_blk_req;
    logic               r_xors_valid;
    logic [8:0]         r_blk_index;
    logic               r_frame_busy;
    logic               r_frame_done;
    logic               r_frame_overrun;
    logic               r_proto_err;

    logic               w_gap_done;
    logic               w_last;
    logic               w_issue;
    logic [8:0]         w_idx;

    assign w_gap_done = (r_gap == '0);
    assign w_last     = (r_x == c_last_x) && (r_y == c_last_y);
    assign w_issue    = (r_state == c_WAIT_RES) && !r_xors_valid &&
                        result_valid && stream_ready && w_gap_done;
    assign w_idx      = 9'(int'(r_y) * c_blk_cols + int'(r_x));

    // The last block stays in WAIT_RES for its issue cycle so that DONE
    // coincides with the frame_done pulse.
    always_comb begin
        w_next_state = r_state;
        w_next_x     = r_x;
        w_next_y     = r_y;
        case (r_state)
            c_IDLE: begin
                if (frame_start) begin
                    w_next_state = c_REQ;
                    w_next_x     = 4'd0;
                    w_next_y     = 5'd0;
                end
            end
            c_REQ: begin
                if (blk_ack) begin
                    w_next_state = c_WAIT_RES;
                end
            end
            c_WAIT_RES: begin
                if (r_xors_valid) begin
                    w_next_state = c_DONE;
                end else if (w_issue && !w_last) begin
                    w_next_state = c_REQ;
                    if (r_x == c_last_x) begin
                        w_next_x = 4'd0;
                        w_next_y = r_y + 5'd1;
                    end else begin
                        w_next_x = r_x + 4'd1;
                    end
                end
            end
            c_DONE: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_x             <= 4'd0;
            r_y             <= 5'd0;
            r_gap           <= '0;
            r_blk_req       <= 1'b0;
            r_xors_valid    <= 1'b0;
            r_blk_index     <= 9'd0;
            r_frame_busy    <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_overrun <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_x          <= w_next_x;
            r_y          <= w_next_y;
            r_blk_req    <= (w_next_state == c_REQ);
            r_xors_valid <= w_issue;
            r_frame_busy <= (w_next_state == c_REQ) || (w_next_state == c_WAIT_RES);
            r_frame_done <= (w_next_state == c_DONE);
            if (w_issue) begin
                r_blk_index <= w_idx;
                r_gap       <= c_gap_reload;
            end else if (!w_gap_done) begin
                r_gap <= r_gap - 1'b1;
            end
            if (frame_start && (r_state != c_IDLE)) begin
                r_frame_overrun <= 1'b1;
            end
            // The engine legitimately still holds result_valid in the cycle
            // where result_taken is high.
            if (result_valid && (r_state != c_WAIT_RES) && !r_xors_valid) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign blk_req       = r_blk_req;
    assign blk_x         = r_x;
    assign blk_y         = r_y;
    assign xors_valid    = r_xors_valid;
    assign result_taken  = r_xors_valid;
    assign blk_index     = r_blk_index;
    assign frame_busy    = r_frame_busy;
    assign frame_done    = r_frame_done;
    assign frame_overrun = r_frame_overrun;
    assign proto_err     = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_block_match_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_match_scheduler
// Description : Directed vector table plus full-frame sequences with a
//               behavioural compare engine and a monitor scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_match_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       blk_req;
    logic [3:0] blk_x;
    logic [4:0] blk_y;
    logic       blk_ack = 1'b0;
    logic       result_valid = 1'b0;
    logic       stream_ready = 1'b0;
    logic       xors_valid;
    logic       result_taken;
    logic [8:0] blk_index;
    logic       frame_busy;
    logic       frame_done;
    logic       frame_overrun;
    logic       proto_err;

    block_match_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .blk_req       (blk_req),
        .blk_x         (blk_x),
        .blk_y         (blk_y),
        .blk_ack       (blk_ack),
        .result_valid  (result_valid),
        .stream_ready  (stream_ready),
        .xors_valid    (xors_valid),
        .result_taken  (result_taken),
        .blk_index     (blk_index),
        .frame_busy    (frame_busy),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [24:0] outs();
        return {blk_req, blk_x, blk_y, xors_valid, result_taken, blk_index,
                frame_busy, frame_done, frame_overrun, proto_err};
    endfunction

    // Behavioural compare engine: acks after ack_delay low cycles, presents
    // the result right after the handshake and holds it until result_taken.
    bit eng_en    = 1'b0;
    int ack_delay = 0;
    int ack_cnt   = 0;

    always @(negedge clk) begin
        if (eng_en) begin
            if (reset) begin
                blk_ack      = 1'b0;
                result_valid = 1'b0;
                ack_cnt      = 0;
            end else begin
                if (result_taken) result_valid = 1'b0;
                if (blk_ack && !blk_req) begin
                    blk_ack      = 1'b0;
                    result_valid = 1'b1;
                    ack_cnt      = 0;
                end else if (blk_req) begin
                    if (ack_cnt >= ack_delay) blk_ack = 1'b1;
                    else begin
                        blk_ack = 1'b0;
                        ack_cnt++;
                    end
                end
            end
        end
    end

    // Monitor scoreboard
    bit         mon_en    = 1'b0;
    bit         skip_gap  = 1'b0;
    int         exp_idx   = 0;
    int         pulse_cnt = 0;
    int         done_cnt  = 0;
    int         last_cyc  = 0;
    bit         prev_req  = 1'b0;
    logic [3:0] prev_x    = '0;
    logic [4:0] prev_y    = '0;

    task automatic sb_clear();
        exp_idx   = 0;
        pulse_cnt = 0;
        done_cnt  = 0;
        prev_req  = 1'b0;
        skip_gap  = 1'b0;
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en) begin
            if (prev_req) begin
                if (blk_ack) chk("req_drop", int'(blk_req), 0);
                else chk("req_hold", int'({blk_req, blk_x, blk_y}), int'({1'b1, prev_x, prev_y}));
            end
            if (xors_valid || result_taken)
                chk("taken_eq_valid", int'(result_taken), int'(xors_valid));
            if (xors_valid) begin
                chk("idx_order", int'(blk_index), exp_idx);
                chk("idx_coords", int'(blk_index), int'(prev_y) * 15 + int'(prev_x));
                chk("issue_qual", int'({stream_ready, result_valid}), 3);
                if (blk_index == 9'd14) chk("wrap_14", int'({prev_x, prev_y}), int'({4'd14, 5'd0}));
                if (blk_index == 9'd15) chk("wrap_15", int'({prev_x, prev_y}), int'({4'd0, 5'd1}));
                if (pulse_cnt > 0) begin
                    if (skip_gap) begin
                        chk("gap_min", int'(cyc - last_cyc >= 128), 1);
                        skip_gap = 1'b0;
                    end else begin
                        chk("gap_exact", cyc - last_cyc, 128);
                    end
                end
                exp_idx++;
                pulse_cnt++;
                last_cyc = cyc;
            end
            if (frame_done) begin
                chk("done_timing", cyc, last_cyc + 1);
                chk("done_count", pulse_cnt, 450);
                chk("done_busy", int'(frame_busy), 0);
                done_cnt++;
            end
            prev_req = blk_req;
            prev_x   = blk_x;
            prev_y   = blk_y;
        end
    end

    task automatic wait_pulses(input int n, input int budget, input string name);
        int k = 0;
        while (pulse_cnt < n && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk(name, int'(pulse_cnt >= n), 1);
    endtask

    typedef struct {
        logic       rst, fs, ack, rv, sr;
        logic       req;
        logic [3:0] x;
        logic [4:0] y;
        logic       xv;
        logic [8:0] idx;
        logic       busy, done, ovr, perr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // rst fs ack rv sr | req x y xv idx busy done ovr perr
        tbl[0]  = '{1,1,1,1,1, 0,0,0,0,0,0,0,0,0};
        tbl[1]  = '{1,0,0,0,0, 0,0,0,0,0,0,0,0,0};
        tbl[2]  = '{0,0,0,0,0, 0,0,0,0,0,0,0,0,0};
        tbl[3]  = '{0,1,0,0,0, 1,0,0,0,0,1,0,0,0};
        tbl[4]  = '{0,0,0,0,0, 1,0,0,0,0,1,0,0,0};
        tbl[5]  = '{0,0,1,0,0, 0,0,0,0,0,1,0,0,0};
        tbl[6]  = '{0,0,0,1,0, 0,0,0,0,0,1,0,0,0};
        tbl[7]  = '{0,0,0,1,1, 1,1,0,1,0,1,0,0,0};
        tbl[8]  = '{0,0,0,0,0, 1,1,0,0,0,1,0,0,0};
        tbl[9]  = '{0,0,1,0,0, 0,1,0,0,0,1,0,0,0};
        tbl[10] = '{0,0,0,1,1, 0,1,0,0,0,1,0,0,0};
        tbl[11] = '{0,1,0,0,0, 0,1,0,0,0,1,0,1,0};
        tbl[12] = '{1,0,0,0,0, 0,0,0,0,0,0,0,0,0};
        tbl[13] = '{0,0,0,1,0, 0,0,0,0,0,0,0,0,1};
        tbl[14] = '{1,0,0,0,0, 0,0,0,0,0,0,0,0,0};
        tbl[15] = '{0,1,0,0,0, 1,0,0,0,0,1,0,0,0};

        // Reset held 5 cycles with random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset        = 1'b1;
            frame_start  = 1'($urandom_range(0, 1));
            blk_ack      = 1'($urandom_range(0, 1));
            result_valid = 1'($urandom_range(0, 1));
            stream_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
            chk("reset_outs", int'(outs()), 0);
        end
        @(negedge clk);
        reset = 1'b0; frame_start = 1'b0; blk_ack = 1'b0; result_valid = 1'b0; stream_ready = 1'b0;
        @(posedge clk);
        #2;
        chk("post_reset_outs", int'(outs()), 0);

        // Directed single-cycle vectors
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            reset        = tbl[i].rst;
            frame_start  = tbl[i].fs;
            blk_ack      = tbl[i].ack;
            result_valid = tbl[i].rv;
            stream_ready = tbl[i].sr;
            @(posedge clk);
            #2;
            chk($sformatf("vec%0d", i), int'(outs()),
                int'({tbl[i].req, tbl[i].x, tbl[i].y, tbl[i].xv, tbl[i].xv, tbl[i].idx,
                      tbl[i].busy, tbl[i].done, tbl[i].ovr, tbl[i].perr}));
        end

        // Full frame: slow acks, stream stall, overrun and protocol error
        @(negedge clk);
        reset = 1'b1; frame_start = 1'b0; blk_ack = 1'b0; result_valid = 1'b0;
        stream_ready = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        ack_delay = 20;
        eng_en    = 1'b1;
        sb_clear();
        mon_en    = 1'b1;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;

        wait_pulses(10, 3000, "reach_blk10");
        @(negedge clk);
        stream_ready = 1'b0;
        repeat (500) @(negedge clk);
        stream_ready = 1'b1;
        skip_gap     = 1'b1;
        @(posedge clk);
        #2;
        chk("resume_valid", int'(xors_valid), 1);
        chk("resume_idx", int'(blk_index), 10);

        wait_pulses(50, 6000, "reach_blk50");
        chk("flags_clean", int'({frame_overrun, proto_err}), 0);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(posedge clk);
        #2;
        chk("overrun_set", int'(frame_overrun), 1);

        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(blk_req && !xors_valid && !result_valid && !blk_ack) && k < 400);
            chk("find_req", int'(k < 400), 1);
        end
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("proto_set", int'(proto_err), 1);
        ack_delay = 0;

        begin
            int k = 0;
            while (done_cnt == 0 && k < 60000) begin
                @(posedge clk);
                #2;
                k++;
            end
            chk("frame_done_seen", int'(done_cnt), 1);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("single_done", done_cnt, 1);
        chk("final_pulses", pulse_cnt, 450);
        chk("sticky_flags", int'({frame_overrun, proto_err, frame_busy}), 6);

        // Flags clear only on reset; then mid-frame reset at block 200
        @(negedge clk);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #2;
        chk("flags_cleared", int'({frame_overrun, proto_err}), 0);
        @(negedge clk);
        reset = 1'b0;
        sb_clear();
        mon_en = 1'b1;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_pulses(200, 30000, "reach_blk200");
        @(negedge clk);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #2;
        chk("midframe_reset_outs", int'(outs()), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("idle_after_reset", int'(outs()), 0);

        @(negedge clk);
        sb_clear();
        mon_en      = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        #2;
        chk("restart_req", int'(outs()), int'({1'b1, 4'd0, 5'd0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        frame_start = 1'b0;
        wait_pulses(2, 500, "restart_pulses");
        chk("restart_overrun", int'({frame_overrun, proto_err}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
